// File: rtl/dice_race_pkg.sv
// Shared types and constants for the dice race board logic.
// Includes the saturating tile adder used to advance a player.
package dice_race_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_DICE = 3'd1,
        S_MOVE      = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_WIN       = 3'd4
    } state_e;

    localparam int TILE_W = 4;
    localparam int N_TILES_DEFAULT = 16;
    localparam logic [TILE_W-1:0] FINISH_TILE = TILE_W'(N_TILES_DEFAULT - 1);

    localparam logic PLAYER1 = 1'b0;
    localparam logic PLAYER2 = 1'b1;

    // The sum is formed one bit wider so an overshoot past the finish tile cannot wrap.
    function automatic logic [TILE_W-1:0] sat_add(input logic [TILE_W-1:0] pos,
                                                  input logic [2:0]        dice,
                                                  input logic [TILE_W-1:0] limit);
        logic [TILE_W:0] sum;
        sum = {1'b0, pos} + (TILE_W+1)'(dice);
        if (sum > {1'b0, limit}) begin
            return limit;
        end else begin
            return sum[TILE_W-1:0];
        end
    endfunction

endpackage

// File: rtl/game_turn_controller.sv
// Turn sequencer for the dice race: accepts rolls, moves the active player,
// then waits for the renderer (or a watchdog) before checking for a winner.
module game_turn_controller
    import dice_race_pkg::*;
#(
    parameter int N_TILES        = 16,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int DICE_MAX       = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              game_start,
    input  logic              dice_valid,
    input  logic [2:0]        dice_value,
    input  logic              turn_done,
    output logic [TILE_W-1:0] p1_pos,
    output logic [TILE_W-1:0] p2_pos,
    output logic              turn,
    output logic              pos_valid,
    output logic              winner_valid,
    output logic              winner,
    output logic              dice_err,
    output logic              busy
);

    localparam logic [TILE_W-1:0] FINISH = TILE_W'(N_TILES - 1);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : {CNT_W{1'b0}};
    localparam logic [2:0] DMAX = 3'(DICE_MAX);

    state_e            state_r;
    logic [2:0]        dice_r;
    logic [CNT_W-1:0]  cnt_r;

    logic [TILE_W-1:0] active_pos_s;
    logic [TILE_W-1:0] moved_pos_s;
    logic              dice_ok_s;
    logic              timed_out_s;
    logic              wait_exit_s;

    // Move arithmetic, dice legality and the wait-exit condition.
    always_comb begin
        active_pos_s = (turn == PLAYER2) ? p2_pos : p1_pos;
        moved_pos_s  = sat_add(active_pos_s, dice_r, FINISH);
        dice_ok_s    = (dice_value != 3'd0) && (dice_value <= DMAX);
        timed_out_s  = (TIMEOUT_CYCLES != 0) && (cnt_r == CNT_LAST);
        wait_exit_s  = turn_done || timed_out_s;
    end

    // Game FSM with all outputs registered; game_start overrides everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= S_IDLE;
            dice_r       <= 3'd0;
            cnt_r        <= {CNT_W{1'b0}};
            p1_pos       <= {TILE_W{1'b0}};
            p2_pos       <= {TILE_W{1'b0}};
            turn         <= PLAYER1;
            pos_valid    <= 1'b0;
            winner_valid <= 1'b0;
            winner       <= 1'b0;
            dice_err     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            pos_valid <= 1'b0;
            dice_err  <= 1'b0;
            if (game_start) begin
                state_r      <= S_WAIT_DICE;
                cnt_r        <= {CNT_W{1'b0}};
                p1_pos       <= {TILE_W{1'b0}};
                p2_pos       <= {TILE_W{1'b0}};
                turn         <= PLAYER1;
                winner_valid <= 1'b0;
                winner       <= 1'b0;
                busy         <= 1'b0;
            end else begin
                case (state_r)
                    S_IDLE: begin
                        state_r <= S_IDLE;
                    end
                    S_WAIT_DICE: begin
                        if (dice_valid) begin
                            if (dice_ok_s) begin
                                dice_r  <= dice_value;
                                busy    <= 1'b1;
                                state_r <= S_MOVE;
                            end else begin
                                dice_err <= 1'b1;
                            end
                        end
                    end
                    S_MOVE: begin
                        if (turn == PLAYER2) begin
                            p2_pos <= moved_pos_s;
                        end else begin
                            p1_pos <= moved_pos_s;
                        end
                        pos_valid <= 1'b1;
                        cnt_r     <= {CNT_W{1'b0}};
                        state_r   <= S_WAIT_DONE;
                    end
                    S_WAIT_DONE: begin
                        if (wait_exit_s) begin
                            busy  <= 1'b0;
                            cnt_r <= {CNT_W{1'b0}};
                            if (active_pos_s == FINISH) begin
                                winner       <= turn;
                                winner_valid <= 1'b1;
                                state_r      <= S_WIN;
                            end else begin
                                turn    <= ~turn;
                                state_r <= S_WAIT_DICE;
                            end
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1'b1);
                        end
                    end
                    S_WIN: begin
                        state_r <= S_WIN;
                    end
                    default: begin
                        state_r <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
